// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M multiply/divide unit with valid/ready handshake
module alu_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Result,
  output logic            busy
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        op_q;
  logic              sa_q, sb_q;
  logic [XLEN-1:0]   b_q, result_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN:0]     rem_q;
  logic              sa, sb, div_zero, div_ovf, neg;
  logic [XLEN-1:0]   a_mag, b_mag, spec_res, quo_s, rem_s, fin;
  logic [XLEN:0]     mul_sum, rem_d;
  logic [XLEN+1:0]   diff;
  logic [2*XLEN-1:0] acc_d, prod_s;
  assign in_ready  = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign out_valid = state_q == DONE;
  assign Result    = result_q;
  always_comb begin
    sa       = (funct3 inside {3'b001, 3'b010, 3'b100, 3'b110}) & A[XLEN-1];
    sb       = (funct3 inside {3'b001, 3'b100, 3'b110}) & B[XLEN-1];
    a_mag    = sa ? -A : A;
    b_mag    = sb ? -B : B;
    div_zero = funct3[2] & (B == '0);
    div_ovf  = funct3[2] & ~funct3[0] & (A == {1'b1, {(XLEN-1){1'b0}}}) & (&B);
    spec_res = div_zero ? (funct3[1] ? A : '1) : (funct3[1] ? '0 : A);
    // Low half of acc_q holds the multiplier bits or the dividend bits being shifted out
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    diff     = {rem_q, acc_q[XLEN-1]} - {2'b0, b_q};
    rem_d    = diff[XLEN+1] ? {rem_q[XLEN-1:0], acc_q[XLEN-1]} : diff[XLEN:0];
    acc_d    = op_q[2] ? {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~diff[XLEN+1]}
                       : {mul_sum, acc_q[XLEN-1:1]};
    neg      = sa_q ^ sb_q;
    prod_s   = neg ? -acc_d : acc_d;
    quo_s    = neg ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
    rem_s    = sa_q ? -rem_d[XLEN-1:0] : rem_d[XLEN-1:0];
    fin      = op_q[2] ? (op_q[1] ? rem_s : quo_s)
                       : (op_q[1:0] == 2'b00 ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else if (state_q == IDLE) begin
      if (in_valid && !flush) begin
        op_q    <= funct3;
        sa_q    <= sa;
        sb_q    <= sb;
        b_q     <= b_mag;
        acc_q   <= {{XLEN{1'b0}}, a_mag};
        rem_q   <= '0;
        cnt_q   <= '0;
        state_q <= (div_zero || div_ovf) ? DONE : CALC;
        if (div_zero || div_ovf) result_q <= spec_res;
      end
    end else if (flush) begin
      state_q <= IDLE;
    end else if (state_q == CALC) begin
      acc_q <= acc_d;
      rem_q <= rem_d;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CW'(XLEN-1)) begin
        state_q  <= DONE;
        result_q <= fin;
      end
    end else if (out_ready) begin
      state_q <= IDLE;
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: randomized and directed checks of alu_muldiv against an arithmetic model
module tb_alu_muldiv;
  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready, in_ready, out_valid, busy;
  logic [2:0] funct3;
  logic [31:0] A, B, Result;
  logic in_valid16, out_ready16, in_ready16, out_valid16, busy16;
  logic [2:0] funct3_16;
  logic [15:0] A16, B16, Result16;
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .busy(busy)
  );

  alu_muldiv #(.XLEN(16)) dut16 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid16), .in_ready(in_ready16),
    .funct3(funct3_16), .A(A16), .B(B16), .out_valid(out_valid16), .out_ready(out_ready16),
    .Result(Result16), .busy(busy16)
  );

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint ps, psu;
    logic [63:0] pu;
    logic ovf;
    ps  = longint'($signed(a)) * longint'($signed(b));
    psu = longint'($signed(a)) * longint'({32'b0, b});
    pu  = {32'b0, a} * {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: return pu[31:0];
      3'd1: return ps[63:32];
      3'd2: return psu[63:32];
      3'd3: return pu[63:32];
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
  endfunction

  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     output logic [31:0] r, output int lat);
    @(negedge clk);
    funct3 = f; A = a; B = b; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    r = Result;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
    checks++; if (Result !== 32'h0) $display("FAIL reset_result got %h exp 0", Result); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [2:0]  f [10] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] a [10] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                            32'hFFFF_FFF9, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b [10] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2,
                            32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] e [10] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int el [10] = '{33, 33, 33, 33, 33, 33, 1, 1, 1, 1};
    logic [31:0] r;
    int lat;
    for (int i = 0; i < 10; i++) begin
      run(f[i], a[i], b[i], r, lat);
      checks++; if (r !== e[i]) $display("FAIL directed_%0d result got %h exp %h", i, r, e[i]); else passed++;
      checks++; if (lat != el[i]) $display("FAIL directed_%0d latency got %0d exp %0d", i, lat, el[i]); else passed++;
    end
  endtask

  task automatic test_random;
    logic [2:0] f;
    logic [31:0] a, b, r;
    int lat, k;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 7);
      f = 3'($urandom_range(0, 7));
      a = (k == 1) ? 32'h8000_0000 : (k == 3) ? 32'($urandom_range(0, 20)) : $urandom;
      b = (k == 0) ? 32'd0 : (k == 2) ? 32'hFFFF_FFFF : (k == 4) ? 32'($urandom_range(1, 9)) : $urandom;
      run(f, a, b, r, lat);
      checks++;
      if (r !== model(f, a, b)) $display("FAIL random_%0d f3=%0d a=%h b=%h got %h exp %h", i, f, a, b, r, model(f, a, b));
      else passed++;
      checks++;
      if (lat != model_lat(f, a, b)) $display("FAIL random_lat_%0d got %0d exp %0d", i, lat, model_lat(f, a, b));
      else passed++;
    end
  endtask

  task automatic test_backpressure;
    int n = 0;
    @(negedge clk);
    funct3 = 3'd3; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++; if (Result !== 32'hFFFF_FFFE) $display("FAIL hold_result_%0d got %h exp fffffffe", i, Result); else passed++;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) $display("FAIL hold_hs_%0d got in_ready=%b out_valid=%b exp 0/1", i, in_ready, out_valid); else passed++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL release got out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready); else passed++;
  endtask

  task automatic test_flush;
    logic [31:0] r;
    int lat;
    bit seen = 0;
    run(3'd0, 32'd3, 32'd5, r, lat);
    checks++; if (r !== 32'd15) $display("FAIL flush_pre got %h exp 0000000f", r); else passed++;
    @(negedge clk);
    funct3 = 3'd5; A = $urandom; B = 32'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL flush_state got busy=%b out_valid=%b exp 0/0", busy, out_valid); else passed++;
    checks++; if (Result !== 32'd15) $display("FAIL flush_result got %h exp 0000000f", Result); else passed++;
    repeat (40) begin
      @(negedge clk);
      seen |= out_valid;
    end
    checks++; if (seen) $display("FAIL flush_no_valid got 1 exp 0"); else passed++;
    funct3 = 3'd5; A = 32'd9; B = 32'd0; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL flush_idle_block got busy=%b exp 0", busy); else passed++;
  endtask

  task automatic test_rst_mid;
    @(negedge clk);
    funct3 = 3'd0; A = 32'd123; B = 32'd456; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b1) $display("FAIL rst_mid_busy_before got %b exp 1", busy); else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL rst_mid_state got busy=%b out_valid=%b exp 0/0", busy, out_valid); else passed++;
    checks++; if (Result !== 32'h0) $display("FAIL rst_mid_result got %h exp 0", Result); else passed++;
  endtask

  task automatic test_back_to_back;
    int nv = 0;
    @(negedge clk);
    funct3 = 3'd7; A = 32'h1234; B = 32'd0; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) begin
        nv++;
        checks++; if (Result !== 32'h1234) $display("FAIL b2b_result_%0d got %h exp 00001234", i, Result); else passed++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (nv != 4) $display("FAIL b2b_count got %0d exp 4", nv); else passed++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_xlen16;
    int lat;
    @(negedge clk);
    funct3_16 = 3'd1; A16 = 16'h8000; B16 = 16'h8000; in_valid16 = 1'b1;
    @(negedge clk);
    in_valid16 = 1'b0;
    lat = 1;
    while (!out_valid16 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (Result16 !== 16'h4000) $display("FAIL x16_mulh got %h exp 4000", Result16); else passed++;
    checks++; if (lat != 17) $display("FAIL x16_latency got %0d exp 17", lat); else passed++;
    out_ready16 = 1'b1;
    @(negedge clk);
    out_ready16 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; funct3 = '0; A = '0; B = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; funct3_16 = '0; A16 = '0; B16 = '0;
    test_reset;
    test_directed;
    test_random;
    test_backpressure;
    test_flush;
    test_rst_mid;
    test_back_to_back;
    test_xlen16;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Iterative RV32M multiply/divide unit, parametrised in datapath width. It executes the eight M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) alongside the single-cycle integer ALU. Upstream decode steers an instruction here when opcode = 0110011 and funct7 = 0000001, and passes only funct3 and the operands. Operands enter and results leave over a valid/ready handshake. Core ops use a one-bit-per-cycle shift-add or restoring-divide loop; divide special cases are resolved early.

## Interface
- XLEN, 32: operand/result width, ≥ 8, even.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, active-high; every output returns to its reset value on the next edge.
- flush  in  1  abort the operation in flight.
- in_valid  in  1  operands and funct3 valid.
- in_ready  out  1  unit can accept; reset value 1.
- funct3  in  3  selects the op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- A  in  XLEN  rs1 operand.
- B  in  XLEN  rs2 operand.
- out_valid  out  1  Result valid; reset value 0.
- out_ready  in  1  consumer takes Result.
- Result  out  XLEN  operation result; reset value 0.
- busy  out  1  state ≠ IDLE; reset value 0.

## Operation
- States: IDLE, CALC, DONE.
- in_ready = (state == IDLE). A transfer happens when in_valid & in_ready on an edge. The unit latches funct3, the operand sign flags, and the operand magnitudes.
- Signedness:
  - A is signed for MULH, MULHSU, DIV, REM.
  - B is signed for MULH, DIV, REM.
  - MUL's low half is sign-agnostic; treat it as unsigned.
- Accept from IDLE:
  - DIV/REM/DIVU/REMU with B = 0 → DONE directly.
    - Quotient = all-ones.
    - Remainder = A unmodified.
  - DIV/REM with A = 1<<(XLEN-1) and B = all-ones → DONE directly.
    - Quotient = A.
    - Remainder = 0.
  - Otherwise → CALC, iteration counter = 0.
- CALC, multiply: shift-add on magnitudes, one multiplier bit per edge, into a 2·XLEN accumulator.
- CALC, divide: restoring division on magnitudes, one quotient bit per edge. Remainder register is XLEN+1 bits.
- After iteration XLEN-1, the state moves to DONE. On the same edge, Result is written with the sign correction applied.
  - Product sign = sA ^ sB; negate all 2·XLEN bits.
  - Quotient sign = sA ^ sB.
  - Remainder takes the sign of A.
- Result selection:
  - MUL: low XLEN bits.
  - MULH/MULHSU/MULHU: high XLEN bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- DONE: out_valid = 1 and Result is held stable until an edge with out_ready = 1, then → IDLE. in_ready stays 0 in DONE, so there is no same-edge re-accept.
- flush: when high on an edge with state ≠ IDLE → IDLE, out_valid 0, Result unchanged. In IDLE, flush blocks acceptance on that edge. flush has priority over out_ready.
- rst has priority over flush and all other inputs. Mid-operation it clears state to IDLE, Result to 0, and the counter to 0.

## Timing
- Accept at edge k, core op:
  - CALC runs edges k+1 … k+XLEN.
  - out_valid is high from just after edge k+XLEN.
  - Latency is XLEN+1 cycles from the accept cycle; 33 when XLEN = 32.
- Accept at edge k, special case: out_valid is high from just after edge k, 1 cycle of latency.
- out_valid falls on the edge where out_ready = 1 is sampled. in_ready rises on that same edge. The earliest next accept is the following edge.
- out_ready = 1 throughout gives a minimum initiation interval of XLEN+2 cycles (core) or 2 cycles (special).
- in_valid is ignored while busy; the source must hold in_valid until in_ready.
- Outputs are registered; there is no combinational path from any input to out_valid or Result. in_ready depends only on state.

## Test plan
- MUL: XLEN=32, MUL 7 × 0xFFFFFFFD → Result 0xFFFFFFEB, out_valid 33 cycles after accept. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- Signed high products: MULH 0x80000000 × 0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide: DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM 0xFFFFFFF9 % 2 → 0xFFFFFFFF.
- Divide by zero: DIVU 5 / 0 → 0xFFFFFFFF and REMU 5 % 0 → 5, each with out_valid 1 cycle after accept.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0, each 1-cycle latency.
- Control:
  - out_ready held low 5 cycles → Result stable, in_ready 0.
  - flush at CALC cycle 10 → IDLE next edge, no out_valid.
  - rst mid-CALC → busy 0, Result 0.
  - Repeat one MUL at XLEN = 16: 0x8000 × 0x8000 → MULH 0x4000, latency 17.
